// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the arbiter and the shared
// synchronous-read memory.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_we;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        m_en;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_we;
    logic [31:0] m_rdata;

    // Arbiter view
    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_wdata, d_we, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output m_en, m_addr, m_wdata, m_we
    );

    // Requester/memory view
    modport master (
        output i_req, i_addr, d_req, d_addr, d_wdata, d_we, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  m_en, m_addr, m_wdata, m_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one single-cycle synchronous memory.
// Data normally wins; a starved instruction fetch is forced through after STARVE_LIMIT losses.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    owner_t     owner_reg, owner_next;
    logic [3:0] starve_cnt_reg, starve_cnt_next;
    logic       grant_i, grant_d;
    logic       rvalid_i, rvalid_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_reg      <= OWN_NONE;
            starve_cnt_reg <= 4'd0;
        end else begin
            owner_reg      <= owner_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    always_comb begin
        grant_i         = 1'b0;
        grant_d         = 1'b0;
        owner_next      = OWN_NONE;
        starve_cnt_next = starve_cnt_reg;
        if (!reset) begin
            if (bus.i_req && bus.d_req) begin
                if (starve_cnt_reg >= LIMIT) begin
                    grant_i = 1'b1;
                end else begin
                    grant_d = 1'b1;
                    if (starve_cnt_reg != 4'hF) begin
                        starve_cnt_next = starve_cnt_reg + 4'd1;
                    end
                end
            end else if (bus.i_req) begin
                grant_i = 1'b1;
            end else if (bus.d_req) begin
                grant_d = 1'b1;
            end

            if (grant_i) begin
                starve_cnt_next = 4'd0;
                owner_next      = OWN_INSTR;
            end else if (grant_d) begin
                owner_next      = OWN_DATA;
            end
        end
    end

    // Owner is still registered during a reset cycle, so responses are masked by reset too.
    assign rvalid_i = !reset && (owner_reg == OWN_INSTR);
    assign rvalid_d = !reset && (owner_reg == OWN_DATA);

    always_comb begin
        bus.i_gnt    = grant_i;
        bus.d_gnt    = grant_d;
        bus.m_en     = grant_i | grant_d;
        bus.m_addr   = 32'd0;
        bus.m_wdata  = 32'd0;
        bus.m_we     = 4'b0000;
        if (grant_i) begin
            bus.m_addr  = bus.i_addr;
        end else if (grant_d) begin
            bus.m_addr  = bus.d_addr;
            bus.m_wdata = bus.d_wdata;
            bus.m_we    = bus.d_we;
        end
    end

    // Store completions carry no data, so d_rdata needs the pending access type.
    logic store_reg;
    always_ff @(posedge clk) begin
        if (reset) begin
            store_reg <= 1'b0;
        end else begin
            store_reg <= grant_d && (bus.d_we != 4'b0000);
        end
    end

    always_comb begin
        bus.i_rvalid = rvalid_i;
        bus.d_rvalid = rvalid_d;
        bus.i_rdata  = rvalid_i ? bus.m_rdata : 32'd0;
        bus.d_rdata  = (rvalid_d && !store_reg) ? bus.m_rdata : 32'd0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-stepped scoreboard bench for mem_arbiter: grants checked in-cycle,
// responses pushed at grant time and popped/compared the following cycle.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
    } rsp_t;
    rsp_t sb_q[$];

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Shared memory stand-in: synchronous read, garbage when idle so gating is visible.
    always @(posedge clk) begin
        bus.m_rdata <= bus.m_en ? mem_word(bus.m_addr) : 32'hBAD0_BAD0;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "/i_gnt"},    32'(bus.i_gnt),    32'd0);
        check_eq({tag, "/d_gnt"},    32'(bus.d_gnt),    32'd0);
        check_eq({tag, "/i_rvalid"}, 32'(bus.i_rvalid), 32'd0);
        check_eq({tag, "/d_rvalid"}, 32'(bus.d_rvalid), 32'd0);
        check_eq({tag, "/m_en"},     32'(bus.m_en),     32'd0);
        check_eq({tag, "/m_we"},     32'(bus.m_we),     32'd0);
        check_eq({tag, "/m_addr"},   bus.m_addr,        32'd0);
        check_eq({tag, "/m_wdata"},  bus.m_wdata,       32'd0);
        check_eq({tag, "/i_rdata"},  bus.i_rdata,       32'd0);
        check_eq({tag, "/d_rdata"},  bus.d_rdata,       32'd0);
    endtask

    // One clock of stimulus; exp_g: 0 none, 1 instruction, 2 data.
    task automatic cycle(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic [31:0] da,
                         input logic [3:0] dwe, input logic [31:0] dwd,
                         input int exp_g, input string tag);
        rsp_t e;
        bus.i_req = ir; bus.i_addr = ia;
        bus.d_req = dr; bus.d_addr = da; bus.d_we = dwe; bus.d_wdata = dwd;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq({tag, "/i_rvalid"}, 32'(bus.i_rvalid), 32'(e.port == 1));
            check_eq({tag, "/d_rvalid"}, 32'(bus.d_rvalid), 32'(e.port == 2));
            check_eq({tag, "/i_rdata"},  bus.i_rdata, (e.port == 1) ? e.data : 32'd0);
            check_eq({tag, "/d_rdata"},  bus.d_rdata, (e.port == 2) ? e.data : 32'd0);
        end else begin
            check_eq({tag, "/i_rvalid_idle"}, 32'(bus.i_rvalid), 32'd0);
            check_eq({tag, "/d_rvalid_idle"}, 32'(bus.d_rvalid), 32'd0);
            check_eq({tag, "/i_rdata_idle"},  bus.i_rdata, 32'd0);
            check_eq({tag, "/d_rdata_idle"},  bus.d_rdata, 32'd0);
        end
        check_eq({tag, "/i_gnt"}, 32'(bus.i_gnt), 32'(exp_g == 1));
        check_eq({tag, "/d_gnt"}, 32'(bus.d_gnt), 32'(exp_g == 2));
        check_eq({tag, "/m_en"},  32'(bus.m_en),  32'(exp_g != 0));
        check_eq({tag, "/m_addr"},  bus.m_addr,  (exp_g == 1) ? ia : (exp_g == 2) ? da : 32'd0);
        check_eq({tag, "/m_wdata"}, bus.m_wdata, (exp_g == 2) ? dwd : 32'd0);
        check_eq({tag, "/m_we"},    32'(bus.m_we), (exp_g == 2) ? 32'(dwe) : 32'd0);
        $display("[%0t] %s: i_gnt=%0b d_gnt=%0b m_addr=%h i_rv=%0b d_rv=%0b",
                 $time, tag, bus.i_gnt, bus.d_gnt, bus.m_addr, bus.i_rvalid, bus.d_rvalid);
        if (exp_g == 1) sb_q.push_back('{1, mem_word(ia)});
        if (exp_g == 2) sb_q.push_back('{2, (dwe == 4'b0000) ? mem_word(da) : 32'd0});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_seq[6];
        exp_seq = '{2, 2, 2, 2, 1, 2};

        // Requests present during reset must be ignored.
        reset = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 32'h40;
        bus.d_req = 1'b1; bus.d_addr = 32'h80; bus.d_we = 4'hF; bus.d_wdata = 32'h1234_5678;
        repeat (2) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        cycle(1'b1, 32'h10, 1'b0, 32'h0, 4'h0, 32'h0, 1, "instr_only");
        cycle(1'b0, 32'h0, 1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF, 2, "store");
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 0, "idle_after_store");

        // Contention: data wins four times, then instruction is forced through.
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 32'h200, 1'b1, 32'h500 + 32'(4 * k), 4'h0, 32'hCAFE_0000,
                  exp_seq[k], $sformatf("starve%0d", k + 1));
        end
        cycle(1'b1, 32'h300, 1'b0, 32'h0, 4'h0, 32'h0, 1, "clear_cnt");

        // Back-to-back alternating traffic.
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0)
                cycle(1'b1, 32'h400 + 32'(4 * k), 1'b0, 32'h0, 4'h0, 32'h0, 1,
                      $sformatf("alt%0d_i", k));
            else
                cycle(1'b0, 32'h0, 1'b1, 32'h600 + 32'(4 * k), (k % 4 == 1) ? 4'h0 : 4'h3,
                      32'h0BAD_F00D + 32'(k), 2, $sformatf("alt%0d_d", k));
        end

        // Build up starvation, then drop a losing data request.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 32'h800, 1'b1, 32'h880 + 32'(4 * k), 4'h0, 32'h0, 2,
                  $sformatf("prep%0d", k));
        end
        cycle(1'b1, 32'h800, 1'b1, 32'h900, 4'h0, 32'h5555_AAAA, 1, "d_loses");
        cycle(1'b1, 32'h804, 1'b0, 32'h0, 4'h0, 32'h0, 1, "d_dropped");
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 0, "drain_drop");

        // Reset right after a load grant kills the response.
        cycle(1'b0, 32'h0, 1'b1, 32'h700, 4'h0, 32'h0, 2, "load_pre_reset");
        reset = 1'b1;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        @(negedge clk);
        check_all_zero("reset_after_load");
        sb_q.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("reset_hold");
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1'b1, 32'hA0, 1'b0, 32'h0, 4'h0, 32'h0, 1, "post_reset");
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 0, "final_drain");

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
